// File: rtl/sub16_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sub16_pipe
// Function : Two-stage pipelined 16-bit subtractor (d = a - b - bin) with
//            borrow in/out, signed overflow and zero flags, and valid/ready
//            handshakes on both sides. Low byte in stage 1, carry-select
//            upper byte in stage 2.
// Revision : 1.0  initial release
// ============================================================================
module sub16_pipe (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        bin,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] d,
   output logic        bout,
   output logic        ovf,
   output logic        zero
);

   // Stage 1 state: low-byte result plus operands of the upper byte.
   logic [7:0]  lo_q, lo_d;
   logic        c8_q, c8_d;
   logic [7:0]  ah_q, ah_d;
   logic [7:0]  nbh_q, nbh_d;
   logic        a15_q, a15_d;
   logic        b15_q, b15_d;
   logic        s1_valid_q, s1_valid_d;

   // Stage 2 state: registered outputs.
   logic [15:0] d_q, d_d;
   logic        bout_q, bout_d;
   logic        ovf_q, ovf_d;
   logic        zero_q, zero_d;
   logic        out_valid_q, out_valid_d;

   logic        s2_advance;
   logic        in_fire;
   logic [8:0]  lo_sum;
   logic [4:0]  mid0, mid1, mid_sel;
   logic [4:0]  hi0, hi1, hi_sel;
   logic [15:0] diff;

   // Stage 2 can take new data when empty or when its result leaves now.
   assign s2_advance = !out_valid_q || out_ready;
   assign in_ready   = !s1_valid_q || s2_advance;
   assign in_fire    = in_valid && in_ready;

   // Stage 1 next state: low byte a + ~b + ~bin, stash upper-byte operands.
   always_comb begin
      lo_sum     = {1'b0, a[7:0]} + {1'b0, ~b[7:0]} + {8'h00, ~bin};
      lo_d       = lo_q;
      c8_d       = c8_q;
      ah_d       = ah_q;
      nbh_d      = nbh_q;
      a15_d      = a15_q;
      b15_d      = b15_q;
      s1_valid_d = s1_valid_q;
      if (in_fire) begin
         lo_d       = lo_sum[7:0];
         c8_d       = lo_sum[8];
         ah_d       = a[15:8];
         nbh_d      = ~b[15:8];
         a15_d      = a[15];
         b15_d      = b[15];
         s1_valid_d = 1'b1;
      end else if (s2_advance) begin
         s1_valid_d = 1'b0;
      end
   end

   // Stage 2 next state: two 4-bit carry-select slices over the upper byte.
   always_comb begin
      mid0    = {1'b0, ah_q[3:0]} + {1'b0, nbh_q[3:0]};
      mid1    = {1'b0, ah_q[3:0]} + {1'b0, nbh_q[3:0]} + 5'd1;
      hi0     = {1'b0, ah_q[7:4]} + {1'b0, nbh_q[7:4]};
      hi1     = {1'b0, ah_q[7:4]} + {1'b0, nbh_q[7:4]} + 5'd1;
      mid_sel = c8_q ? mid1 : mid0;
      hi_sel  = mid_sel[4] ? hi1 : hi0;
      diff    = {hi_sel[3:0], mid_sel[3:0], lo_q};

      d_d         = d_q;
      bout_d      = bout_q;
      ovf_d       = ovf_q;
      zero_d      = zero_q;
      out_valid_d = out_valid_q;
      if (s2_advance) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            d_d    = diff;
            bout_d = ~hi_sel[4];
            ovf_d  = (a15_q != b15_q) && (diff[15] != a15_q);
            zero_d = (diff == 16'h0000);
         end
      end
   end

   // Pipeline registers; reset discards anything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_q        <= 8'h00;
         c8_q        <= 1'b0;
         ah_q        <= 8'h00;
         nbh_q       <= 8'h00;
         a15_q       <= 1'b0;
         b15_q       <= 1'b0;
         s1_valid_q  <= 1'b0;
         d_q         <= 16'h0000;
         bout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         lo_q        <= lo_d;
         c8_q        <= c8_d;
         ah_q        <= ah_d;
         nbh_q       <= nbh_d;
         a15_q       <= a15_d;
         b15_q       <= b15_d;
         s1_valid_q  <= s1_valid_d;
         d_q         <= d_d;
         bout_q      <= bout_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign d         = d_q;
   assign bout      = bout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;
   assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sub16_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub16_pipe
// Function : Self-checking bench for sub16_pipe: directed corner vectors,
//            backpressure, asynchronous reset mid-flight, and a randomized
//            run against an arithmetic reference model with a scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_sub16_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        bin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] d;
   logic        bout;
   logic        ovf;
   logic        zero;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [15:0] d;
      logic        bout;
      logic        ovf;
      logic        zero;
   } res_t;

   res_t exp_q[$];

   // Output-hold tracking across a stalled cycle.
   logic        prev_stall = 1'b0;
   logic [18:0] prev_out   = '0;

   sub16_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .bout      (bout),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views.
   function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin);
      res_t r;
      int ua, ub, sa, sb, ib, udiff, sdiff;
      ua    = int'(ma);
      ub    = int'(mb);
      sa    = int'($signed(ma));
      sb    = int'($signed(mb));
      ib    = mbin ? 1 : 0;
      udiff = ua - ub - ib;
      sdiff = sa - sb - ib;
      r.d    = udiff[15:0];
      r.bout = (udiff < 0);
      r.ovf  = (sdiff < -32768) || (sdiff > 32767);
      r.zero = (r.d == 16'h0000);
      return r;
   endfunction

   // Inputs are set just after a falling edge; sample, score, then step one cycle.
   task automatic tick();
      res_t e;
      #1;
      if (prev_stall) begin
         check_val("hold", {out_valid, bout, ovf, zero, d[14:0]}, prev_out);
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_out", {16'h0, d}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check_val("sb_d", {16'h0, d}, {16'h0, e.d});
            check_val("sb_flags", {29'h0, bout, ovf, zero}, {29'h0, e.bout, e.ovf, e.zero});
         end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, bout, ovf, zero, d[14:0]};
      if (in_valid && in_ready) exp_q.push_back(model(a, b, bin));
      @(posedge clk);
      @(negedge clk);
   endtask

   // One operation with out_ready high, checking latency and fixed expectations.
   task automatic directed(input string tag, input logic [15:0] da, input logic [15:0] db,
                           input logic dbin, input logic [15:0] ed, input logic eb,
                           input logic eo, input logic ez);
      a = da; b = db; bin = dbin; in_valid = 1'b1; out_ready = 1'b1;
      #1 check_val({tag, "_in_ready"}, {31'h0, in_ready}, 32'h1);
      tick();
      in_valid = 1'b0;
      #1 check_val({tag, "_lat_s1"}, {31'h0, out_valid}, 32'h0);
      tick();
      #1;
      check_val({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
      check_val({tag, "_d"}, {16'h0, d}, {16'h0, ed});
      check_val({tag, "_flags"}, {29'h0, bout, ovf, zero}, {29'h0, eb, eo, ez});
      tick();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; bin = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check_val("rst_valid", {31'h0, out_valid}, 32'h0);
      check_val("rst_outs", {13'h0, bout, ovf, zero, d}, 32'h0);
      check_val("rst_in_ready", {31'h0, in_ready}, 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check_val("rel_in_ready", {31'h0, in_ready}, 32'h1);
      @(negedge clk);

      directed("plain",  16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
      directed("under",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      directed("sovf",   16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
      directed("bsplit", 16'h0100, 16'h00FF, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
      directed("wrap0",  16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

      // Backpressure: three offers with out_ready low, only two fit.
      out_ready = 1'b0; in_valid = 1'b1; b = 16'h0000; bin = 1'b0;
      a = 16'h0001; tick();
      a = 16'h0002; tick();
      a = 16'h0003;
      #1;
      check_val("bp_in_ready", {31'h0, in_ready}, 32'h0);
      check_val("bp_held_d", {15'h0, out_valid, d}, {15'h0, 1'b1, 16'h0001});
      repeat (3) tick();
      out_ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         #1 check_val("bp_order", {15'h0, out_valid, d}, {15'h0, 1'b1, 16'(i)});
         tick();
         in_valid = 1'b0;
      end
      #1 check_val("bp_once", {31'h0, out_valid}, 32'h0);
      check_val("bp_sb_empty", exp_q.size(), 0);

      // Reset with both stages full: asynchronous clear, nothing stale afterwards.
      out_ready = 1'b0; in_valid = 1'b1;
      a = 16'h0009; b = 16'h0001; tick();
      a = 16'h0008; tick();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_valid", {31'h0, out_valid}, 32'h0);
      check_val("arst_d", {16'h0, d}, 32'h0);
      check_val("arst_in_ready", {31'h0, in_ready}, 32'h1);
      exp_q.delete();
      prev_stall = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1 check_val("arel_in_ready", {31'h0, in_ready}, 32'h1);
      tick();
      check_val("arel_no_stale", {31'h0, out_valid}, 32'h0);
      directed("post_rst", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

      // Randomized traffic with corner-biased operands and random stalls.
      for (int n = 0; n < 600; n++) begin
         logic [15:0] corners [6];
         corners = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h00FF, 16'h0100};
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         a   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
         b   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
         bin = 1'($urandom);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 10 && exp_q.size() != 0; n++) tick();
      check_val("drain", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
